// File: rtl/rvvi_trace_pkg.sv
// Shared record layout and checker state encoding for the RVVI retire path.
package rvvi_trace_pkg;

    // Integer register width carried in pc and rd_data. The record layout is
    // shared by every block on the trace path, so it is fixed here.
    localparam int XLEN = 64;

    // One retired instruction. The order field is at the MSB end of the record.
    typedef struct packed {
        logic [63:0]     order;
        logic [31:0]     insn;
        logic [XLEN-1:0] pc;
        logic            trap;
        logic            debug_mode;
        logic [1:0]      mode;
        logic [4:0]      rd;
        logic            rd_wb;
        logic [XLEN-1:0] rd_data;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    typedef enum logic [1:0] {
        CHK_IDLE  = 2'd0,
        CHK_TRACK = 2'd1,
        CHK_ERROR = 2'd2
    } chk_state_e;

endpackage

// File: rtl/rvvi_order_checker.sv
// Watches the ORDER field of each popped record and flags any step other than +1.
module rvvi_order_checker
    import rvvi_trace_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pop,
    input  logic [63:0] head_order,
    input  logic        err_clr,
    output logic        order_err,
    output logic [63:0] err_expected
);

    chk_state_e  state_q, state_d;
    logic [63:0] expected_q, expected_d;
    logic        order_err_q, order_err_d;
    logic [63:0] err_expected_q, err_expected_d;
    logic        mismatch;

    assign mismatch     = (head_order != expected_q);
    assign order_err    = order_err_q;
    assign err_expected = err_expected_q;

    // Next-state: err_clr is applied first so a mismatching pop in the same cycle overrides it.
    always_comb begin
        // NOTE: every output of this block gets a default first; otherwise a path
        // that skips an assignment would infer a latch.
        state_d        = state_q;
        expected_d     = expected_q;
        order_err_d    = order_err_q;
        err_expected_d = err_expected_q;

        if (err_clr) begin
            order_err_d    = 1'b0;
            err_expected_d = '0;
            if (state_q == CHK_ERROR) begin
                state_d = CHK_TRACK;
            end
        end

        if (pop) begin
            // Resync on every pop; wraps from all-ones to zero naturally.
            expected_d = head_order + 64'd1;
            case (state_q)
                CHK_IDLE: begin
                    state_d = CHK_TRACK;
                end
                CHK_TRACK: begin
                    if (mismatch) begin
                        order_err_d    = 1'b1;
                        err_expected_d = expected_q;
                        state_d        = CHK_ERROR;
                    end
                end
                CHK_ERROR: begin
                    // Only a freshly cleared error may capture a new expected value.
                    if (mismatch && err_clr) begin
                        order_err_d    = 1'b1;
                        err_expected_d = expected_q;
                        state_d        = CHK_ERROR;
                    end
                end
                default: begin
                    state_d = CHK_IDLE;
                end
            endcase
        end
    end

    // Checker state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= CHK_IDLE;
            expected_q     <= '0;
            order_err_q    <= 1'b0;
            err_expected_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples the pre-edge value regardless of statement order.
            state_q        <= state_d;
            expected_q     <= expected_d;
            order_err_q    <= order_err_d;
            err_expected_q <= err_expected_d;
        end
    end

endmodule

// File: rtl/rvvi_retire_serializer.sv
// Compacts up to NRET retired records per cycle into a FIFO and replays them one per cycle.
module rvvi_retire_serializer
    import rvvi_trace_pkg::*;
#(
    parameter  int NRET  = 2,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NRET-1:0]       in_valid,
    input  logic [NRET*REC_W-1:0] in_rec,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output trace_rec_t            out_rec,
    input  logic                  err_clr,
    output logic                  order_err,
    output logic [63:0]           err_expected,
    output logic [CNT_W-1:0]      occupancy,
    output logic [CNT_W-1:0]      high_water
);

    // Accept only when a full NRET-wide burst fits without counting a same-cycle pop.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - NRET);

    trace_rec_t       mem_q [DEPTH];
    trace_rec_t       wr_data [DEPTH];
    logic [DEPTH-1:0] wr_en;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, high_water_q, high_water_d;
    logic [CNT_W-1:0] push_cnt;
    logic [PTR_W-1:0] slot;
    logic             push, pop;

    assign in_ready   = (count_q <= READY_MAX);
    assign out_valid  = (count_q != '0);
    assign out_rec    = mem_q[rd_ptr_q];
    assign push       = in_ready && (|in_valid);
    assign pop        = out_valid && out_ready;
    assign occupancy  = count_q;
    assign high_water = high_water_q;

    // Compaction: the k-th valid lane (ascending) lands at wr_ptr + k.
    always_comb begin
        wr_en    = '0;
        push_cnt = '0;
        slot     = '0;
        for (int e = 0; e < DEPTH; e++) begin
            wr_data[e] = '0;
        end
        for (int i = 0; i < NRET; i++) begin
            if (in_valid[i]) begin
                slot          = wr_ptr_q + PTR_W'(push_cnt);
                wr_en[slot]   = push;
                wr_data[slot] = trace_rec_t'(in_rec[i*REC_W +: REC_W]);
                push_cnt      = push_cnt + CNT_W'(1);
            end
        end
    end

    // Pointer, count and high-water next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
            count_d  = count_q + push_cnt;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_d - CNT_W'(1);
        end
        high_water_d = (count_d > high_water_q) ? count_d : high_water_q;
    end

    // Control registers; reset discards anything buffered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            high_water_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            high_water_q <= high_water_d;
        end
    end

    // Record storage.
    // NOTE: the storage array has no reset; entries are only read while count
    // marks them live, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (wr_en[e]) begin
                mem_q[e] <= wr_data[e];
            end
        end
    end

    rvvi_order_checker u_checker (
        .clk          (clk),
        .reset_n      (reset_n),
        .pop          (pop),
        .head_order   (out_rec.order),
        .err_clr      (err_clr),
        .order_err    (order_err),
        .err_expected (err_expected)
    );

endmodule

// File: tb/tb_rvvi_retire_serializer.sv
// Directed bench for rvvi_retire_serializer (NRET=2, DEPTH=8).
module tb_rvvi_retire_serializer;
    import rvvi_trace_pkg::*;

    localparam int NRET  = 2;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  clk;
    logic                  reset_n;
    logic [NRET-1:0]       in_valid;
    logic [NRET*REC_W-1:0] in_rec;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    trace_rec_t            out_rec;
    logic                  err_clr;
    logic                  order_err;
    logic [63:0]           err_expected;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W-1:0]      high_water;

    int checks = 0;
    int errors = 0;

    rvvi_retire_serializer #(.NRET(NRET), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_rec       (in_rec),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rec      (out_rec),
        .err_clr      (err_clr),
        .order_err    (order_err),
        .err_expected (err_expected),
        .occupancy    (occupancy),
        .high_water   (high_water)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Deterministic record contents derived from the order number.
    function automatic trace_rec_t mk(input logic [63:0] o);
        trace_rec_t r;
        r.order      = o;
        r.insn       = o[31:0] ^ 32'h0000_0013;
        r.pc         = (o << 2) + 64'h8000_0000;
        r.trap       = o[0];
        r.debug_mode = 1'b0;
        r.mode       = 2'b11;
        r.rd         = o[4:0];
        r.rd_wb      = o[1];
        r.rd_data    = ~o;
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; everything is driven and sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1);
        in_valid = v;
        in_rec   = {mk(o1), mk(o0)};
    endtask

    task automatic do_reset();
        in_valid  = '0;
        in_rec    = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        reset_n   = 1'b0;
        #2;
        reset_n   = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = '0;
        in_rec    = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        step();
        step();

        // Reset state.
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_occupancy", 256'(occupancy), 256'(0));
        check("rst_high_water", 256'(high_water), 256'(0));
        check("rst_order_err", 256'(order_err), 256'(0));
        check("rst_err_expected", 256'(err_expected), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        reset_n = 1'b1;
        step();

        // Two-lane push, drained one per cycle.
        set_lanes(2'b11, 64'd1, 64'd2);
        out_ready = 1'b1;
        step();
        in_valid = '0;
        check("t1_out_valid", 256'(out_valid), 256'(1));
        check("t1_rec_1", 256'(out_rec), 256'(mk(64'd1)));
        check("t1_high_water", 256'(high_water), 256'(2));
        step();
        check("t1_rec_2", 256'(out_rec), 256'(mk(64'd2)));
        check("t1_occ_1", 256'(occupancy), 256'(1));
        step();
        check("t1_empty", 256'(out_valid), 256'(0));
        check("t1_order_err", 256'(order_err), 256'(0));
        check("t1_high_water_hold", 256'(high_water), 256'(2));

        // Lane 1 only: compacted into slot 0.
        do_reset();
        set_lanes(2'b10, 64'd99, 64'd5);
        step();
        in_valid = '0;
        check("t2_occ", 256'(occupancy), 256'(1));
        check("t2_mem0", 256'(dut.mem_q[0].order), 256'(64'd5));
        check("t2_rec", 256'(out_rec), 256'(mk(64'd5)));
        out_ready = 1'b1;
        step();
        check("t2_state", 256'(dut.u_checker.state_q), 256'(CHK_TRACK));
        check("t2_expected", 256'(dut.u_checker.expected_q), 256'(64'd6));
        check("t2_occ_0", 256'(occupancy), 256'(0));

        // Fill to DEPTH under backpressure, then drain with pointer wrap.
        do_reset();
        set_lanes(2'b11, 64'd1, 64'd2);
        step();
        set_lanes(2'b11, 64'd3, 64'd4);
        step();
        set_lanes(2'b11, 64'd5, 64'd6);
        step();
        check("t3_occ_6", 256'(occupancy), 256'(6));
        check("t3_ready_at_6", 256'(in_ready), 256'(1));
        set_lanes(2'b11, 64'd7, 64'd8);
        step();
        check("t3_occ_8", 256'(occupancy), 256'(8));
        check("t3_ready_at_8", 256'(in_ready), 256'(0));
        check("t3_high_water", 256'(high_water), 256'(8));
        set_lanes(2'b11, 64'd9, 64'd10);
        step();
        check("t3_occ_hold", 256'(occupancy), 256'(8));
        check("t3_head_1", 256'(out_rec), 256'(mk(64'd1)));
        out_ready = 1'b1;
        step();
        check("t3_occ_7", 256'(occupancy), 256'(7));
        check("t3_ready_at_7", 256'(in_ready), 256'(0));
        check("t3_head_2", 256'(out_rec), 256'(mk(64'd2)));
        step();
        check("t3_occ_6b", 256'(occupancy), 256'(6));
        check("t3_ready_at_6b", 256'(in_ready), 256'(1));
        check("t3_head_3", 256'(out_rec), 256'(mk(64'd3)));
        step();
        in_valid = '0;
        check("t3_occ_7b", 256'(occupancy), 256'(7));
        for (int k = 4; k <= 10; k++) begin
            check("t3_drain", 256'(out_rec), 256'(mk(64'(k))));
            step();
        end
        check("t3_empty", 256'(out_valid), 256'(0));
        check("t3_order_err", 256'(order_err), 256'(0));
        check("t3_high_water_end", 256'(high_water), 256'(8));

        // Order gap detection, sticky err_expected, and clear.
        do_reset();
        set_lanes(2'b11, 64'd10, 64'd11);
        step();
        set_lanes(2'b11, 64'd13, 64'd14);
        step();
        set_lanes(2'b01, 64'd16, 64'd0);
        step();
        in_valid  = '0;
        out_ready = 1'b1;
        step();
        step();
        check("t4_no_err_11", 256'(order_err), 256'(0));
        step();
        check("t4_err_13", 256'(order_err), 256'(1));
        check("t4_err_exp_13", 256'(err_expected), 256'(64'd12));
        step();
        step();
        check("t4_err_exp_16", 256'(err_expected), 256'(64'd12));
        check("t4_state_err", 256'(dut.u_checker.state_q), 256'(CHK_ERROR));
        check("t4_occ_0", 256'(occupancy), 256'(0));
        out_ready = 1'b0;
        err_clr   = 1'b1;
        step();
        err_clr = 1'b0;
        check("t4_clr_err", 256'(order_err), 256'(0));
        check("t4_clr_exp", 256'(err_expected), 256'(0));
        check("t4_clr_state", 256'(dut.u_checker.state_q), 256'(CHK_TRACK));
        // Mismatching pop coincident with err_clr: the error wins.
        set_lanes(2'b01, 64'd20, 64'd0);
        step();
        in_valid  = '0;
        out_ready = 1'b1;
        err_clr   = 1'b1;
        step();
        err_clr   = 1'b0;
        out_ready = 1'b0;
        check("t4_clr_race_err", 256'(order_err), 256'(1));
        check("t4_clr_race_exp", 256'(err_expected), 256'(64'd17));

        // ORDER wrap through 2^64-1 -> 0 is not an error.
        do_reset();
        set_lanes(2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        set_lanes(2'b11, 64'd0, 64'd1);
        step();
        in_valid  = '0;
        out_ready = 1'b1;
        step();
        step();
        check("t5_head_0", 256'(out_rec), 256'(mk(64'd0)));
        step();
        step();
        check("t5_no_err", 256'(order_err), 256'(0));
        check("t5_occ_0", 256'(occupancy), 256'(0));
        check("t5_expected", 256'(dut.u_checker.expected_q), 256'(64'd2));

        // Asynchronous reset with five entries buffered.
        do_reset();
        set_lanes(2'b11, 64'd1, 64'd2);
        step();
        set_lanes(2'b11, 64'd3, 64'd4);
        step();
        set_lanes(2'b01, 64'd5, 64'd0);
        step();
        in_valid = '0;
        check("t6_occ_5", 256'(occupancy), 256'(5));
        reset_n = 1'b0;
        #1;
        check("t6_async_occ", 256'(occupancy), 256'(0));
        check("t6_async_valid", 256'(out_valid), 256'(0));
        check("t6_async_ready", 256'(in_ready), 256'(1));
        #1;
        reset_n = 1'b1;
        set_lanes(2'b01, 64'd100, 64'd0);
        out_ready = 1'b1;
        step();
        in_valid = '0;
        check("t6_rec_100", 256'(out_rec), 256'(mk(64'd100)));
        step();
        check("t6_no_err", 256'(order_err), 256'(0));
        check("t6_occ_0", 256'(occupancy), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
